// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (core A, host/debug B) arbiter in front of a single-port data memory
// Define DMEM_ARB_FIXED_PRIO_EN to give port A fixed priority instead of round robin.
module dmem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_e,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              own_b;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              arb_pt;
  logic              any_req;
  logic              both_req;
  logic              win_b;

  assign arb_pt   = (state == IDLE) || (state == DONE);
  assign any_req  = a_req || b_req;
  assign both_req = a_req && b_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win_b = !a_req;
`else
  // last_b resets to 1 so that A wins the very first contention
  logic last_b;

  assign win_b = both_req ? !last_b : b_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (arb_pt && any_req) begin
      last_b <= win_b;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_e     = 1'b0;
    mem_we    = 1'b0;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = any_req ? ACCESS : IDLE;
      end
      ACCESS: begin
        state_nxt = DONE;
        mem_e     = 1'b1;
        mem_we    = lat_we;
        a_gnt     = !own_b;
        b_gnt     = own_b;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // mem_addr/mem_di are driven straight from the latch so they hold between accesses
  assign mem_addr = lat_addr;
  assign mem_di   = lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_b     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (arb_pt && any_req) begin
      own_b     <= win_b;
      lat_we    <= win_b ? b_we    : a_we;
      lat_addr  <= win_b ? b_addr  : a_addr;
      lat_wdata <= win_b ? b_wdata : a_wdata;
    end
  end

  // mem_do is valid during DONE; capture it on the edge that closes DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= (state == DONE) && !lat_we && !own_b;
      b_rvalid <= (state == DONE) && !lat_we && own_b;
      if ((state == DONE) && !lat_we && !own_b) begin
        a_rdata <= mem_do;
      end
      if ((state == DONE) && !lat_we && own_b) begin
        b_rdata <= mem_do;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 8'd0;
    end else if (arb_pt && both_req && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter with a transaction-level model
module tb_dmem_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_e, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_do = '0;
  logic [7:0]    conflict_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do), .conflict_cnt(conflict_cnt)
  );

  // Data memory seen by the DUT: one-cycle read latency
  logic [DW-1:0] env_mem [16];
  always @(posedge clk) begin
    if (mem_e) begin
      if (mem_we) env_mem[mem_addr] <= mem_di;
      else        mem_do <= env_mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transactions scheduled by cycle number
  logic [DW-1:0] exp_mem [16];
  bit            r_ga [8], r_gb [8], r_rva [8], r_rvb [8];
  logic [DW-1:0] r_rd [8];
  int            cyc, next_arb, cnt;
  bit            last_b;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_di, exp_rd_a, exp_rd_b;
  logic [15:0]   gseq;
  req_t          ra, rb;
  bit            pend_a, pend_b;
  req_t          qa [$];
  req_t          qb [$];

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(1));
    r.addr  = AW'($urandom_range(15));
    r.wdata = DW'($urandom_range(255));
    return r;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_a_gnt"}, 32'(a_gnt), 0);
    chk({pfx, "_b_gnt"}, 32'(b_gnt), 0);
    chk({pfx, "_a_rvalid"}, 32'(a_rvalid), 0);
    chk({pfx, "_b_rvalid"}, 32'(b_rvalid), 0);
    chk({pfx, "_a_rdata"}, 32'(a_rdata), 0);
    chk({pfx, "_b_rdata"}, 32'(b_rdata), 0);
    chk({pfx, "_mem_e"}, 32'(mem_e), 0);
    chk({pfx, "_mem_we"}, 32'(mem_we), 0);
    chk({pfx, "_mem_addr"}, 32'(mem_addr), 0);
    chk({pfx, "_mem_di"}, 32'(mem_di), 0);
    chk({pfx, "_conflict"}, 32'(conflict_cnt), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    pend_a = 0; pend_b = 0;
    qa.delete(); qb.delete();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    cyc = 0; next_arb = 0; cnt = 0; last_b = 1;
    exp_we = 0; exp_addr = '0; exp_di = '0; exp_rd_a = '0; exp_rd_b = '0;
    gseq = '0;
    for (int i = 0; i < 8; i++) begin
      r_ga[i] = 0; r_gb[i] = 0; r_rva[i] = 0; r_rvb[i] = 0; r_rd[i] = '0;
    end
  endtask

  task automatic run(input int ncyc, input int pa, input int pb);
    int  idx, nidx, ridx;
    bit  wb, acc;
    for (int k = 0; k < ncyc; k++) begin
      idx = cyc % 8;
      if (r_rva[idx]) exp_rd_a = r_rd[idx];
      if (r_rvb[idx]) exp_rd_b = r_rd[idx];
      acc = r_ga[idx] || r_gb[idx];
      chk("a_gnt", 32'(a_gnt), 32'(r_ga[idx]));
      chk("b_gnt", 32'(b_gnt), 32'(r_gb[idx]));
      chk("a_rvalid", 32'(a_rvalid), 32'(r_rva[idx]));
      chk("b_rvalid", 32'(b_rvalid), 32'(r_rvb[idx]));
      chk("a_rdata", 32'(a_rdata), 32'(exp_rd_a));
      chk("b_rdata", 32'(b_rdata), 32'(exp_rd_b));
      chk("mem_e", 32'(mem_e), 32'(acc));
      chk("mem_we", 32'(mem_we), 32'(acc && exp_we));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_di", 32'(mem_di), 32'(exp_di));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt));
      r_ga[idx] = 0; r_gb[idx] = 0; r_rva[idx] = 0; r_rvb[idx] = 0;
      if (a_gnt || b_gnt) gseq = {gseq[14:0], b_gnt};

      // Requesters: hold until granted, then release or issue a fresh request
      if (a_gnt) pend_a = 0;
      if (b_gnt) pend_b = 0;
      if (!pend_a) begin
        if (qa.size() > 0) begin ra = qa.pop_front(); pend_a = 1; end
        else if (int'($urandom_range(99)) < pa) begin ra = rand_req(); pend_a = 1; end
      end
      if (!pend_b) begin
        if (qb.size() > 0) begin rb = qb.pop_front(); pend_b = 1; end
        else if (int'($urandom_range(99)) < pb) begin rb = rand_req(); pend_b = 1; end
      end
      a_req = pend_a; a_we = ra.we; a_addr = ra.addr; a_wdata = ra.wdata;
      b_req = pend_b; b_we = rb.we; b_addr = rb.addr; b_wdata = rb.wdata;

      if (cyc == next_arb) begin
        if (a_req || b_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          wb = !a_req;
`else
          wb = (a_req && b_req) ? !last_b : b_req;
`endif
          if (a_req && b_req && cnt < 255) cnt++;
          nidx = (cyc + 1) % 8;
          if (wb) r_gb[nidx] = 1; else r_ga[nidx] = 1;
          exp_we   = wb ? b_we : a_we;
          exp_addr = wb ? b_addr : a_addr;
          exp_di   = wb ? b_wdata : a_wdata;
          if (exp_we) exp_mem[exp_addr] = exp_di;
          else begin
            ridx = (cyc + 3) % 8;
            if (wb) r_rvb[ridx] = 1; else r_rva[ridx] = 1;
            r_rd[ridx] = exp_mem[exp_addr];
          end
          last_b   = wb;
          next_arb = cyc + 2;
        end else begin
          next_arb = cyc + 1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    req_t r;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = DW'($urandom_range(255));
      exp_mem[i] = env_mem[i];
    end
    #2 chk_zero("por");
    do_reset();

    // Write 0x5A to addr 3 then read it back through port A
    r.we = 1; r.addr = 4'd3; r.wdata = 8'h5A; qa.push_back(r);
    r.we = 0; r.addr = 4'd3; r.wdata = 8'h00; qa.push_back(r);
    run(10, 0, 0);
    chk("wr_rd_a_rdata", 32'(a_rdata), 32'h5A);

    // Simultaneous requests: A first, B two cycles later, one conflict
    do_reset();
    r.we = 0; r.addr = 4'd1; qa.push_back(r);
    r.we = 0; r.addr = 4'd2; qb.push_back(r);
    run(10, 0, 0);
    chk("contend_cnt", 32'(conflict_cnt), 1);
    chk("contend_order", 32'(gseq[1:0]), 32'b01);

    // Continuous requests from both ports for six grants
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r = rand_req(); qa.push_back(r);
      r = rand_req(); qb.push_back(r);
    end
    run(20, 0, 0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    chk("grant_seq", 32'(gseq[5:0]), 32'b000111);
`else
    chk("grant_seq", 32'(gseq[5:0]), 32'b010101);
`endif

    // Reset during the DONE cycle of a port-B read of 0x77
    do_reset();
    env_mem[5] = 8'h77;
    exp_mem[5] = 8'h77;
    b_req = 1; b_we = 0; b_addr = 4'd5; b_wdata = '0;
    @(posedge clk);
    #1 chk("abort_b_gnt", 32'(b_gnt), 1);
    b_req = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("abort");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("abort_b_rvalid", 32'(b_rvalid), 0);
    end
    chk("abort_b_rdata", 32'(b_rdata), 0);

    // Mixed random traffic
    do_reset();
    run(400, 40, 60);

    // Saturation of the conflict counter
    do_reset();
    run(700, 100, 100);
    chk("conflict_sat", 32'(conflict_cnt), 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the data-memory address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 a_req / b_req  input  1  SHALL carry the request from port A (core) and port B (host/debug).
REQ-006 a_we / b_we  input  1  SHALL select write (1) or read (0), valid while req is high.
REQ-007 a_addr / b_addr  input  ADDR_W  SHALL carry the access address, valid while req is high.
REQ-008 a_wdata / b_wdata  input  DATA_W  SHALL carry the write data, valid while req is high.
REQ-009 a_gnt / b_gnt  output  1  SHALL pulse for one cycle when that port's access is issued to memory.
REQ-010 a_rvalid / b_rvalid  output  1  SHALL pulse for one cycle when that port's read data is valid.
REQ-011 a_rdata / b_rdata  output  DATA_W  SHALL hold the registered read data, held until the port's next read completes.
REQ-012 mem_e, mem_we  output  1  SHALL drive DMem enable and write-enable.
REQ-013 mem_addr  output  ADDR_W;  mem_di  output  DATA_W  SHALL drive the DMem address and write data.
REQ-014 mem_do  input  DATA_W  SHALL be the DMem read data, valid the cycle after mem_e with mem_we=0.
REQ-015 conflict_cnt  output  8  SHALL count arbitration points at which both requests were high.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-017 IDLE and DONE SHALL be arbitration points: if any req is high, latch the winner's we/addr/wdata and owner, then go to ACCESS; else go to IDLE.
REQ-018 ACCESS SHALL last exactly one cycle: mem_e=1, mem_we/mem_addr/mem_di from the latched request, owner's gnt=1; next state DONE.
REQ-019 In DONE, on a read, the owner's rdata SHALL capture mem_do at the closing edge and its rvalid SHALL be 1 in the following cycle.
REQ-020 On a write, no rvalid SHALL be produced.
REQ-021 Outside ACCESS, mem_e, mem_we and both gnt SHALL be 0; mem_addr/mem_di SHALL hold the latched values.
REQ-022 Latency: req sampled high in IDLE at edge N -> gnt in cycle N+1 -> rvalid in cycle N+3; back-to-back throughput is one access per 2 cycles.
REQ-023 A requester SHALL hold req and its fields stable until it sees gnt, and drop req in the next cycle; req still high in DONE is a new request.
REQ-024 A single requester SHALL always win.
REQ-025 With both requesting, the winner SHALL be the port that did not win the previous grant (round robin); last-winner pointer updates on every grant.
REQ-026 conflict_cnt SHALL increment by 1 at each arbitration point with a_req=b_req=1 and SHALL saturate at 255.
REQ-027 An rvalid pulse for one port SHALL be allowed in the same cycle as a gnt to the other port.

Reset
REQ-028 On rst=1 the block SHALL go to IDLE immediately (asynchronously), aborting any in-flight access.
REQ-029 During reset, all outputs SHALL be 0, and the last-winner pointer SHALL be B so that A wins the first contention.
REQ-030 A read aborted by reset SHALL produce no rvalid after reset release.

Configuration
REQ-031 When macro DMEM_ARB_FIXED_PRIO_EN is defined, port A SHALL win every contention and the round-robin pointer SHALL be removed.
REQ-032 When DMEM_ARB_FIXED_PRIO_EN is undefined, REQ-025 round robin SHALL apply; conflict_cnt SHALL behave identically in both builds.

Verification
REQ-033 Port A writes 0x5A to addr 3, then reads addr 3 -> mem_we=1 with addr 3 in the write's ACCESS cycle; a_rvalid=1 and a_rdata=0x5A three cycles after the read req.
REQ-034 a_req and b_req rise together, each held until granted -> a_gnt first and b_gnt two cycles later; with FIXED_PRIO the same order results; conflict_cnt=1.
REQ-035 Both ports request continuously for 6 grants -> grants alternate A,B,A,B,A,B (round robin), or A only under FIXED_PRIO.
REQ-036 Assert rst in the DONE cycle of a port-B read of 0x77 -> all outputs 0 at once; no b_rvalid after release; b_rdata=0.
REQ-037 Force 300 contended arbitration points -> conflict_cnt stops at 255.
